// File: rtl/codec_init_seq_pkg.sv
// Shared types, constants and register table for the codec init sequencer.
package codec_init_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_WAIT,
    S_NEXT,
    S_DONE,
    S_FAIL
  } state_t;

  localparam int         TBL_LEN  = 11;
  localparam logic [3:0] LAST_IDX = 4'(TBL_LEN - 1);
  localparam logic [3:0] ERR_PASS = 4'hF;
  localparam logic [3:0] ERR_TMO  = 4'h0;

  // {reg[6:0], data[8:0]}; reset first, activate last so the codec only
  // starts once every other register holds its final value.
  function automatic logic [15:0] tbl_word(input logic [3:0] idx);
    logic [15:0] w;
    w = '0;
    case (idx)
      4'd0:    w = {7'd15, 9'h000};
      4'd1:    w = {7'd0,  9'h017};
      4'd2:    w = {7'd1,  9'h017};
      4'd3:    w = {7'd2,  9'h079};
      4'd4:    w = {7'd3,  9'h079};
      4'd5:    w = {7'd4,  9'h012};
      4'd6:    w = {7'd5,  9'h000};
      4'd7:    w = {7'd6,  9'h000};
      4'd8:    w = {7'd7,  9'h00A};
      4'd9:    w = {7'd8,  9'h000};
      4'd10:   w = {7'd9,  9'h001};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/codec_reg_rom.sv
// Combinational lookup of the codec configuration table.
module codec_reg_rom
  import codec_init_pkg::*;
(
  input  logic [3:0]  idx,
  output logic [15:0] word
);

  assign word = tbl_word(idx);

endmodule

// File: rtl/codec_init_seq.sv
// Walks the codec register table through an external I2C write engine,
// restarting the engine per attempt and retrying failed entries.
module codec_init_seq
  import codec_init_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         MAX_TRIES = 3,
  parameter int         RST_HOLD  = 16,
  parameter int         TIMEOUT   = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       i2c_rst,
  output logic [6:0] i2c_addr,
  output logic [6:0] i2c_reg,
  output logic [8:0] i2c_data,
  output logic       i2c_rw,
  input  logic       i2c_done,
  input  logic [3:0] i2c_error,
  output logic       busy,
  output logic       cfg_done,
  output logic       cfg_fail,
  output logic [3:0] fail_index,
  output logic [3:0] fail_code
);

  localparam int              TW        = ($clog2(MAX_TRIES + 1) > 2) ? $clog2(MAX_TRIES + 1) : 2;
  localparam logic [4:0]      HOLD_LAST = 5'(RST_HOLD - 1);
  localparam logic [15:0]     TMO_LIM   = 16'(TIMEOUT);
  localparam logic [TW-1:0]   TRY_LIM   = TW'(MAX_TRIES);

  state_t        state, state_n;
  logic [3:0]    idx, idx_n;
  logic [TW-1:0] tries, tries_n, try_inc;
  logic [4:0]    hold_cnt, hold_cnt_n;
  logic [15:0]   tmo_cnt, tmo_cnt_n;
  logic          done_n, fail_n;
  logic [3:0]    fidx_n, fcode_n;
  logic [15:0]   rom_word;
  logic          err_hit, tmo_hit;

  // The ROM looks up the next index so fields are valid on the LOAD cycle itself.
  codec_reg_rom u_rom (.idx(idx_n), .word(rom_word));

  assign err_hit  = (i2c_error != ERR_TMO) && (i2c_error != ERR_PASS);
  assign tmo_hit  = (tmo_cnt >= TMO_LIM);
  assign try_inc  = (tries == '1) ? tries : tries + TW'(1);
  assign i2c_rst  = (state == S_WAIT);
  assign busy     = (state == S_LOAD) || (state == S_HOLD) ||
                    (state == S_WAIT) || (state == S_NEXT);
  assign i2c_addr = DEV_ADDR;
  assign i2c_rw   = 1'b0;

  // Next-state and datapath update; failures outrank success in WAIT.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    tries_n    = tries;
    hold_cnt_n = hold_cnt;
    tmo_cnt_n  = tmo_cnt;
    done_n     = cfg_done;
    fail_n     = cfg_fail;
    fidx_n     = fail_index;
    fcode_n    = fail_code;
    case (state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_n = S_LOAD;
          idx_n   = '0;
          tries_n = '0;
          done_n  = 1'b0;
          fail_n  = 1'b0;
        end
      end
      S_LOAD: begin
        state_n    = S_HOLD;
        hold_cnt_n = '0;
      end
      S_HOLD: begin
        if (hold_cnt >= HOLD_LAST) begin
          state_n   = S_WAIT;
          tmo_cnt_n = '0;
        end else if (hold_cnt != '1) begin
          hold_cnt_n = hold_cnt + 5'd1;
        end
      end
      S_WAIT: begin
        if (err_hit || tmo_hit) begin
          tries_n = try_inc;
          if (try_inc < TRY_LIM) begin
            state_n    = S_HOLD;
            hold_cnt_n = '0;
          end else begin
            state_n = S_FAIL;
            fail_n  = 1'b1;
            fidx_n  = idx;
            fcode_n = err_hit ? i2c_error : ERR_TMO;
          end
        end else if (i2c_done && (i2c_error == ERR_PASS)) begin
          state_n = S_NEXT;
        end else if (tmo_cnt != '1) begin
          tmo_cnt_n = tmo_cnt + 16'd1;
        end
      end
      S_NEXT: begin
        tries_n = '0;
        if (idx == LAST_IDX) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else begin
          idx_n   = idx + 4'd1;
          state_n = S_LOAD;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and datapath registers; fields latch only on entry to LOAD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      tries      <= '0;
      hold_cnt   <= '0;
      tmo_cnt    <= '0;
      cfg_done   <= 1'b0;
      cfg_fail   <= 1'b0;
      fail_index <= '0;
      fail_code  <= '0;
      i2c_reg    <= '0;
      i2c_data   <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      tries      <= tries_n;
      hold_cnt   <= hold_cnt_n;
      tmo_cnt    <= tmo_cnt_n;
      cfg_done   <= done_n;
      cfg_fail   <= fail_n;
      fail_index <= fidx_n;
      fail_code  <= fcode_n;
      if (state_n == S_LOAD) begin
        i2c_reg  <= rom_word[15:9];
        i2c_data <= rom_word[8:0];
      end
    end
  end

endmodule

// File: tb/tb_codec_init_seq.sv
// Scoreboard bench: expected attempts queued at start, checked as the engine model sees them.
module tb_codec_init_seq;

  localparam int H = 4;
  localparam int T = 40;

  logic       clk, rst, start;
  logic       i2c_rst, i2c_rw, i2c_done, busy, cfg_done, cfg_fail;
  logic [6:0] i2c_addr, i2c_reg;
  logic [8:0] i2c_data;
  logic [3:0] i2c_error, fail_index, fail_code;

  codec_init_seq #(.DEV_ADDR(7'h1A), .MAX_TRIES(3), .RST_HOLD(H), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .start(start),
    .i2c_rst(i2c_rst), .i2c_addr(i2c_addr), .i2c_reg(i2c_reg), .i2c_data(i2c_data),
    .i2c_rw(i2c_rw), .i2c_done(i2c_done), .i2c_error(i2c_error),
    .busy(busy), .cfg_done(cfg_done), .cfg_fail(cfg_fail),
    .fail_index(fail_index), .fail_code(fail_code)
  );

  typedef struct {
    int         idx;
    logic [6:0] r;
    logic [8:0] d;
  } exp_t;

  logic [6:0] tb_reg [11] = '{7'd15, 7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd8, 7'd9};
  logic [8:0] tb_dat [11] = '{9'h000, 9'h017, 9'h017, 9'h079, 9'h079, 9'h012,
                              9'h000, 9'h000, 9'h00A, 9'h000, 9'h001};

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   mode  = 0;
  int   attempts = 0;
  int   tcnt [16];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i);
    exp_t e;
    e.idx = i;
    e.r   = tb_reg[i];
    e.d   = tb_dat[i];
    sbq.push_back(e);
  endtask

  task automatic begin_run(input int m);
    mode     = m;
    attempts = 0;
    for (int i = 0; i < 16; i++) tcnt[i] = 0;
  endtask

  task automatic pulse_start;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  // n = number of negedges with busy=1, counting the current one
  task automatic wait_idle(input int lim, output int n);
    n = 1;
    while (busy && n < lim) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk("idle_reached", 32'(busy), 0);
  endtask

  // Engine model: checks fields when released from reset, answers on 3rd WAIT cycle
  initial begin
    int   cnt;
    int   cur;
    bit   seen;
    exp_t e;
    i2c_done = 0; i2c_error = 0; cnt = 0; seen = 0; cur = 15;
    forever begin
      @(negedge clk);
      if (!i2c_rst) begin
        i2c_done = 0; i2c_error = 0; cnt = 0; seen = 0;
      end else begin
        if (!seen) begin
          seen = 1;
          attempts++;
          chk("sb_pending", 32'(sbq.size() != 0), 1);
          cur = 15;
          if (sbq.size() != 0) begin
            e   = sbq.pop_front();
            cur = e.idx;
            chk("addr", 32'(i2c_addr), 32'h1A);
            chk("rw", 32'(i2c_rw), 0);
            chk($sformatf("reg_e%0d", cur), 32'(i2c_reg), 32'(e.r));
            chk($sformatf("data_e%0d", cur), 32'(i2c_data), 32'(e.d));
          end
          tcnt[cur]++;
        end
        cnt++;
        if (cnt == 3) begin
          i2c_done = 1; i2c_error = 4'hF;
          case (mode)
            1: if (cur == 4 && tcnt[4] == 1) i2c_error = 4'd2;
            2: if (cur == 2) i2c_error = 4'd3;
            3: begin i2c_done = 0; i2c_error = 0; end
            4: if (cur == 5) begin i2c_done = 0; i2c_error = 0; end
            default: ;
          endcase
        end
      end
    end
  end

  initial begin
    int n;
    bit hit;
    rst = 0; start = 0;
    repeat (3) @(negedge clk);
    chk("rst_i2c_rst", 32'(i2c_rst), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(cfg_done), 0);
    chk("rst_fail", 32'(cfg_fail), 0);
    chk("rst_fidx", 32'(fail_index), 0);
    chk("rst_fcode", 32'(fail_code), 0);
    chk("rst_addr", 32'(i2c_addr), 32'h1A);
    chk("rst_reg", 32'(i2c_reg), 0);
    chk("rst_data", 32'(i2c_data), 0);
    rst = 1;
    @(negedge clk);

    // ack-all run, with latency and start-during-WAIT checks
    begin_run(0);
    for (int i = 0; i < 11; i++) push(i);
    pulse_start;
    chk("load_busy", 32'(busy), 1);
    chk("load_reg", 32'(i2c_reg), 15);
    n = 0;
    while (!i2c_rst && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_release_lat", n, H + 1);
    pulse_start;
    chk("wait_start_ignored", 32'(i2c_rst), 1);
    wait_idle(2000, n);
    chk("r1_done", 32'(cfg_done), 1);
    chk("r1_fail", 32'(cfg_fail), 0);
    chk("r1_attempts", attempts, 11);
    chk("r1_sb_left", sbq.size(), 0);

    // rerun after DONE
    begin_run(0);
    for (int i = 0; i < 11; i++) push(i);
    pulse_start;
    chk("rerun_done_clr", 32'(cfg_done), 0);
    wait_idle(2000, n);
    chk("r2_done", 32'(cfg_done), 1);
    chk("r2_attempts", attempts, 11);

    // entry 4 fails once then passes
    begin_run(1);
    for (int i = 0; i < 11; i++) begin
      push(i);
      if (i == 4) push(4);
    end
    pulse_start;
    wait_idle(2000, n);
    chk("r3_done", 32'(cfg_done), 1);
    chk("r3_fail", 32'(cfg_fail), 0);
    chk("r3_e4_tries", tcnt[4], 2);
    chk("r3_sb_left", sbq.size(), 0);

    // entry 2 always errors (done asserted too: failure must win)
    begin_run(2);
    push(0); push(1); push(2); push(2); push(2);
    pulse_start;
    wait_idle(2000, n);
    chk("r4_fail", 32'(cfg_fail), 1);
    chk("r4_done", 32'(cfg_done), 0);
    chk("r4_fidx", 32'(fail_index), 2);
    chk("r4_fcode", 32'(fail_code), 3);
    chk("r4_i2c_rst", 32'(i2c_rst), 0);
    chk("r4_e2_tries", tcnt[2], 3);
    chk("r4_sb_left", sbq.size(), 0);

    // reset during WAIT of entry 5
    begin_run(4);
    for (int i = 0; i < 6; i++) push(i);
    pulse_start;
    hit = 0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(negedge clk);
      if (attempts == 6 && i2c_rst) hit = 1;
    end
    chk("reach_e5_wait", 32'(hit), 1);
    rst = 0;
    @(negedge clk);
    chk("mid_i2c_rst", 32'(i2c_rst), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done", 32'(cfg_done), 0);
    chk("mid_fail", 32'(cfg_fail), 0);
    chk("mid_fidx", 32'(fail_index), 0);
    chk("mid_fcode", 32'(fail_code), 0);
    chk("mid_reg", 32'(i2c_reg), 0);
    chk("mid_data", 32'(i2c_data), 0);
    rst = 1;
    @(negedge clk);
    chk("mid_sb_left", sbq.size(), 0);
    begin_run(0);
    for (int i = 0; i < 11; i++) push(i);
    pulse_start;
    chk("resume_reg", 32'(i2c_reg), 15);
    wait_idle(2000, n);
    chk("r6_done", 32'(cfg_done), 1);
    chk("r6_attempts", attempts, 11);

    // silent engine: three timeouts on entry 0
    begin_run(3);
    push(0); push(0); push(0);
    pulse_start;
    wait_idle(1000, n);
    chk("r7_cycles", n, 1 + 3 * (H + T + 1));
    chk("r7_fail", 32'(cfg_fail), 1);
    chk("r7_fidx", 32'(fail_index), 0);
    chk("r7_fcode", 32'(fail_code), 0);
    chk("r7_attempts", attempts, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/codec_init_seq.md
CODEC_INIT_SEQ -- requirements
Module: codec_init_seq

Interface
REQ-001 Parameter DEV_ADDR, default 7'h1A: codec I2C device address driven on i2c_addr.
REQ-002 Parameter MAX_TRIES, default 3: total attempts per table entry before failure.
REQ-003 Parameter RST_HOLD, default 16: clk cycles i2c_rst is held low before each attempt.
REQ-004 Parameter TIMEOUT, default 50000: clk cycles allowed per attempt, counted from i2c_rst release.
REQ-005 clk  in  1  system clock; the only clock.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  single-cycle request to run the configuration sequence.
REQ-008 i2c_rst  out  1  active-low restart of the downstream I2C write engine.
REQ-009 i2c_addr / i2c_reg / i2c_data / i2c_rw  out  7/7/9/1  transaction fields to the engine; i2c_rw always 0 (write).
REQ-010 i2c_done  in  1  engine completion flag.
REQ-011 i2c_error  in  4  engine status: 0 = in progress, 4'hF = passed, 1..14 = error code.
REQ-012 busy  out  1  sequence in progress.
REQ-013 cfg_done  out  1  all entries written; sticky until the next start or reset.
REQ-014 cfg_fail  out  1  sequence aborted; sticky until the next start or reset.
REQ-015 fail_index / fail_code  out  4/4  table index and i2c_error value (or 4'h0 for timeout) of the aborted entry.

Function
REQ-016 The block SHALL walk a fixed 11-entry table of {reg[6:0], data[8:0]}, indices 0..10, in ascending order.
REQ-017 The FSM SHALL implement the states IDLE, LOAD, HOLD, WAIT, NEXT, DONE and FAIL.
REQ-018 IDLE/DONE/FAIL: i2c_rst=0, and start=1 -> LOAD with index=0, tries=0, cfg_done=0, cfg_fail=0.
REQ-019 LOAD: fields SHALL be registered from the table, stable from this cycle until the attempt ends; -> HOLD.
REQ-020 HOLD: i2c_rst=0 for exactly RST_HOLD cycles, then -> WAIT with i2c_rst=1 and the timeout counter cleared.
REQ-021 WAIT success: i2c_done=1 and i2c_error=4'hF -> NEXT.
REQ-022 WAIT failure: i2c_error in 1..14, or the timeout counter reaching TIMEOUT; failure SHALL take priority over success in the same cycle.
REQ-023 On failure, tries is incremented; if tries < MAX_TRIES -> HOLD for the same index, otherwise -> FAIL, latching fail_index and fail_code.
REQ-024 NEXT: i2c_rst=0 and tries=0; if index=10 -> DONE with cfg_done=1, otherwise index+1 -> LOAD.
REQ-025 busy SHALL be 1 in LOAD, HOLD, WAIT and NEXT, and 0 otherwise.
REQ-026 start while busy SHALL be ignored.
REQ-027 i2c_rst SHALL be 1 only in WAIT, so the engine never runs unattended.
REQ-028 Counters SHALL saturate and never wrap: the hold counter is 5 bits, the timeout counter is 16 bits, tries is 2 bits minimum.
REQ-029 Latency SHALL be one cycle from start to LOAD, and RST_HOLD+1 cycles from LOAD to i2c_rst=1.

Reset
REQ-030 While rst=0 at a clk edge, the block SHALL enter IDLE with i2c_rst=0, busy=0, cfg_done=0, cfg_fail=0, fail_index=0, fail_code=0, index=0, tries=0, and fields={DEV_ADDR,0,0,0}.
REQ-031 Reset mid-sequence SHALL abandon the current transaction with no resume; the next start SHALL restart at index 0.

Structure
REQ-032 Package codec_init_pkg SHALL hold the state enumeration, the table length (11), the error constants (4'hF pass, 4'h0 timeout) and the table contents.
REQ-033 Table order SHALL be: R15=0x000 (reset), R0=0x017, R1=0x017, R2=0x079, R3=0x079, R4=0x012, R5=0x000, R6=0x000, R7=0x00A, R8=0x000, R9=0x001 (activate last).
REQ-034 The table SHALL be the sub-module codec_reg_rom: 4-bit index in, 16-bit {reg,data} out, combinational.

Verification
REQ-035 Ack-all engine model, start pulse -> 11 attempts with addr 0x1A, rw 0, reg/data in REQ-033 order; then cfg_done=1, busy=0, cfg_fail=0.
REQ-036 Entry 4 returns error 4'd2 once, then passes -> entry 4 attempted twice, sequence completes with cfg_done=1.
REQ-037 Entry 2 always returns error 4'd3 -> exactly 3 attempts, then cfg_fail=1, fail_index=2, fail_code=3, i2c_rst=0.
REQ-038 Engine silent (done=0, error=0) -> FAIL after 3x(RST_HOLD+TIMEOUT) cycles approx., fail_index=0, fail_code=0.
REQ-039 rst=0 for one cycle during WAIT at entry 5 -> next cycle all outputs at REQ-030 values; a new start resumes at entry 0.
REQ-040 start pulsed during WAIT is ignored (index unchanged); start after DONE -> cfg_done clears and the sequence reruns from entry 0.
